// File: rtl/icache_fetch_if.sv
// Fetch-side and refill-side signals of the instruction cache, bundled for port hookup.
interface icache_fetch_if;
  logic [31:0] pc_i;
  logic        flush_i;
  logic [31:0] instr_o;
  logic        inst_stall_o;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_ready_i;
  logic [31:0] mem_rdata_i;
  logic [15:0] miss_cnt_o;

  // Cache side
  modport slave (
    input  pc_i, flush_i, mem_ready_i, mem_rdata_i,
    output instr_o, inst_stall_o, mem_req_o, mem_addr_o, miss_cnt_o
  );

  // Fetch stage / memory side
  modport master (
    output pc_i, flush_i, mem_ready_i, mem_rdata_i,
    input  instr_o, inst_stall_o, mem_req_o, mem_addr_o, miss_cnt_o
  );
endinterface

// File: rtl/icache_fetch.sv
// Direct-mapped read-only instruction cache with in-order line refill and fence.i flush.
module icache_fetch #(
  parameter int unsigned LINES = 16,
  parameter int unsigned WORDS = 4
) (
  input logic           clk,
  input logic           rst,
  icache_fetch_if.slave bus
);

  localparam int unsigned OffW = $clog2(WORDS);
  localparam int unsigned IdxW = $clog2(LINES);
  localparam int unsigned TagW = 30 - OffW - IdxW;
  localparam logic [31:0] Nop  = 32'h0000_0013;
  localparam logic [OffW-1:0] LastBeat = OffW'(WORDS - 1);

  typedef enum logic {StIdle, StRefill} state_e;

  state_e            state_q, state_d;
  logic [LINES-1:0]  valid_q, valid_d;
  logic [TagW-1:0]   ltag_q, ltag_d;
  logic [IdxW-1:0]   lidx_q, lidx_d;
  logic [OffW-1:0]   beat_q, beat_d;
  logic              pend_q, pend_d;
  logic [15:0]       miss_cnt_q, miss_cnt_d;

  logic [TagW-1:0]   tag_mem_q  [LINES];
  logic [31:0]       data_mem_q [LINES][WORDS];

  logic [OffW-1:0]   pc_off;
  logic [IdxW-1:0]   pc_idx;
  logic [TagW-1:0]   pc_tag;
  logic              hit;
  logic              data_we;
  logic              line_done;
  logic              unused_pc;

  assign pc_off    = bus.pc_i[OffW+1:2];
  assign pc_idx    = bus.pc_i[IdxW+OffW+1:OffW+2];
  assign pc_tag    = bus.pc_i[31:IdxW+OffW+2];
  assign unused_pc = ^bus.pc_i[1:0];

  // Lookup only counts while idle; during refill the line being filled is not yet trusted.
  assign hit = (state_q == StIdle) && valid_q[pc_idx] && (tag_mem_q[pc_idx] == pc_tag);

  assign bus.miss_cnt_o = miss_cnt_q;

  // Next-state and output decode for the lookup/refill FSM.
  always_comb begin
    state_d          = state_q;
    valid_d          = valid_q;
    ltag_d           = ltag_q;
    lidx_d           = lidx_q;
    beat_d           = beat_q;
    pend_d           = pend_q;
    miss_cnt_d       = miss_cnt_q;
    data_we          = 1'b0;
    line_done        = 1'b0;
    bus.instr_o      = Nop;
    bus.inst_stall_o = 1'b1;
    bus.mem_req_o    = 1'b0;
    bus.mem_addr_o   = '0;
    case (state_q)
      StIdle: begin
        // Lookup this cycle still sees the old valid bits.
        if (bus.flush_i) valid_d = '0;
        if (hit) begin
          bus.instr_o      = data_mem_q[pc_idx][pc_off];
          bus.inst_stall_o = 1'b0;
        end else begin
          ltag_d     = pc_tag;
          lidx_d     = pc_idx;
          beat_d     = '0;
          miss_cnt_d = miss_cnt_q + 16'd1;
          state_d    = StRefill;
        end
      end
      StRefill: begin
        bus.mem_req_o  = 1'b1;
        bus.mem_addr_o = {ltag_q, lidx_q, beat_q, 2'b00};
        if (bus.flush_i) pend_d = 1'b1;
        if (bus.mem_ready_i) begin
          data_we = 1'b1;
          beat_d  = beat_q + 1'b1;
          if (beat_q == LastBeat) begin
            line_done = 1'b1;
            state_d   = StIdle;
            // A flush seen at any point of the refill leaves the whole cache invalid.
            if (pend_q || bus.flush_i) begin
              valid_d = '0;
              pend_d  = 1'b0;
            end else begin
              valid_d[lidx_q] = 1'b1;
            end
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Control state with synchronous reset; reset aborts any refill in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      valid_q    <= '0;
      ltag_q     <= '0;
      lidx_q     <= '0;
      beat_q     <= '0;
      pend_q     <= 1'b0;
      miss_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      valid_q    <= valid_d;
      ltag_q     <= ltag_d;
      lidx_q     <= lidx_d;
      beat_q     <= beat_d;
      pend_q     <= pend_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  // Tag and data storage; contents are qualified by the valid bits so need no reset.
  always_ff @(posedge clk) begin
    if (data_we) data_mem_q[lidx_q][beat_q] <= bus.mem_rdata_i;
    if (line_done) tag_mem_q[lidx_q] <= ltag_q;
  end

endmodule
